// File: rtl/gpio_pad_ctrl_if.sv
// Serial configuration port of the GPIO pad controller.
interface gpio_pad_ctrl_if;
  logic ser_valid;
  logic ser_data;
  logic ser_load;
  logic ser_busy;
  logic cfg_err;

  modport master (
    output ser_valid,
    output ser_data,
    output ser_load,
    input  ser_busy,
    input  cfg_err
  );

  modport slave (
    input  ser_valid,
    input  ser_data,
    input  ser_load,
    output ser_busy,
    output cfg_err
  );
endinterface

// File: rtl/gpio_pad_ctrl.sv
// GPIO pad controller.
// Configuration arrives serially into a shift chain. It is copied to the
// active register only when exactly NPADS*CFGW bits were shifted. The active
// register drives the per-pad output mux, the input gating and the drive modes.
module gpio_pad_ctrl #(
  parameter int unsigned     NPADS   = 38,
  parameter int unsigned     CFGW    = 6,
  parameter logic [CFGW-1:0] DEF_CFG = CFGW'(6'b001_0_1_1)
) (
  input  logic               clock,
  input  logic               reset,
  gpio_pad_ctrl_if.slave     ser,
  input  logic [NPADS-1:0]   mgmt_out,
  input  logic [NPADS-1:0]   user_out,
  input  logic [NPADS-1:0]   user_oeb,
  output logic [NPADS-1:0]   io_out,
  output logic [NPADS-1:0]   oeb,
  output logic [NPADS-1:0]   inp_dis,
  output logic [3*NPADS-1:0] dm,
  input  logic [NPADS-1:0]   io_in,
  output logic [NPADS-1:0]   mgmt_in,
  output logic [NPADS-1:0]   user_in
);

  localparam int unsigned TOTAL    = NPADS * CFGW;
  localparam int unsigned CNTW     = $clog2(TOTAL + 2);
  localparam int unsigned B_MGMT   = 0;
  localparam int unsigned B_OEB    = 1;
  localparam int unsigned B_INPDIS = 2;
  localparam int unsigned B_DM     = 3;
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(TOTAL);
  localparam logic [CNTW-1:0] CNT_SAT  = CNTW'(TOTAL + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  state_e            state;
  state_e            state_nxt;
  logic [TOTAL-1:0]  chain;
  logic [TOTAL-1:0]  active;
  logic [CNTW-1:0]   cnt;
  logic              cfg_err_q;
  logic [NPADS-1:0]  sync1;
  logic [NPADS-1:0]  sync2;
  logic              shift_en_c;
  logic              cnt_start_c;
  logic              commit_c;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; ser_load is only honoured once a transfer has started
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ser.ser_valid) state_nxt = SHIFT;
      SHIFT:   if (ser.ser_load)  state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded controls; serial bits arriving in COMMIT are dropped
  always_comb begin
    shift_en_c  = 1'b0;
    cnt_start_c = 1'b0;
    commit_c    = 1'b0;
    case (state)
      IDLE: begin
        shift_en_c  = ser.ser_valid;
        cnt_start_c = ser.ser_valid;
      end
      SHIFT:   shift_en_c = ser.ser_valid;
      COMMIT:  commit_c   = 1'b1;
      default: ;
    endcase
  end

  assign ser.ser_busy = commit_c;
  assign ser.cfg_err  = cfg_err_q;

  // Shift chain, saturating bit counter, active config and sticky error
  always_ff @(posedge clock) begin
    if (reset) begin
      chain     <= '0;
      cnt       <= '0;
      active    <= {NPADS{DEF_CFG}};
      cfg_err_q <= 1'b0;
    end else begin
      if (shift_en_c) chain <= {chain[TOTAL-2:0], ser.ser_data};
      if (commit_c) begin
        cnt <= '0;
        if (cnt == CNT_FULL) active    <= chain;
        else                 cfg_err_q <= 1'b1;
      end else if (cnt_start_c) begin
        cnt <= CNTW'(1);
      end else if (shift_en_c && (cnt != CNT_SAT)) begin
        cnt <= cnt + CNTW'(1);
      end
    end
  end

  // Two-flop synchronizer for the asynchronous pad inputs
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= io_in;
      sync2 <= sync1;
    end
  end

  // Per-pad output mux and input routing from the active configuration
  always_comb begin
    io_out  = '0;
    oeb     = '0;
    inp_dis = '0;
    dm      = '0;
    mgmt_in = '0;
    user_in = '0;
    for (int i = 0; i < NPADS; i++) begin
      io_out[i]     = active[i*CFGW + B_MGMT] ? mgmt_out[i] : user_out[i];
      oeb[i]        = active[i*CFGW + B_MGMT] ? active[i*CFGW + B_OEB] : user_oeb[i];
      inp_dis[i]    = active[i*CFGW + B_INPDIS];
      dm[3*i +: 3]  = active[i*CFGW + B_DM +: 3];
      mgmt_in[i]    = sync2[i] &  active[i*CFGW + B_MGMT] & ~active[i*CFGW + B_INPDIS];
      user_in[i]    = sync2[i] & ~active[i*CFGW + B_MGMT] & ~active[i*CFGW + B_INPDIS];
    end
  end

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Scoreboard bench for gpio_pad_ctrl: stimulus queues expected values with
// the cycle they are due, a negedge monitor compares and retires them.
module tb_gpio_pad_ctrl;

  localparam int unsigned NPADS = 38;
  localparam int unsigned CFGW  = 6;
  localparam int unsigned TOTAL = NPADS * CFGW;
  localparam logic [CFGW-1:0] DEF = 6'b001_0_1_1;

  typedef enum int {
    K_OEB, K_IOOUT, K_DM, K_INPDIS, K_MGMTIN, K_USERIN,
    K_ERR, K_BUSY, K_IO5, K_OEB5, K_DM5
  } kind_e;

  typedef struct {
    int           due;
    kind_e        kind;
    logic [127:0] exp;
    string        name;
  } exp_t;

  exp_t sbq[$];

  logic               clock = 1'b0;
  logic               reset;
  logic [NPADS-1:0]   mgmt_out, user_out, user_oeb;
  logic [NPADS-1:0]   io_out, oeb, inp_dis;
  logic [3*NPADS-1:0] dm;
  logic [NPADS-1:0]   io_in, mgmt_in, user_in;

  logic [CFGW-1:0] mcfg [NPADS];
  logic [CFGW-1:0] ncfg [NPADS];

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;
  int lc;
  int c0;
  logic [127:0]     act;
  logic [TOTAL-1:0] junk;

  gpio_pad_ctrl_if ser ();

  gpio_pad_ctrl #(.NPADS(NPADS), .CFGW(CFGW), .DEF_CFG(DEF)) dut (
    .clock    (clock),
    .reset    (reset),
    .ser      (ser),
    .mgmt_out (mgmt_out),
    .user_out (user_out),
    .user_oeb (user_oeb),
    .io_out   (io_out),
    .oeb      (oeb),
    .inp_dis  (inp_dis),
    .dm       (dm),
    .io_in    (io_in),
    .mgmt_in  (mgmt_in),
    .user_in  (user_in)
  );

  initial forever #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [127:0] actual_of(kind_e k);
    case (k)
      K_OEB:    return 128'(oeb);
      K_IOOUT:  return 128'(io_out);
      K_DM:     return 128'(dm);
      K_INPDIS: return 128'(inp_dis);
      K_MGMTIN: return 128'(mgmt_in);
      K_USERIN: return 128'(user_in);
      K_ERR:    return 128'(ser.cfg_err);
      K_BUSY:   return 128'(ser.ser_busy);
      K_IO5:    return 128'(io_out[5]);
      K_OEB5:   return 128'(oeb[5]);
      K_DM5:    return 128'(dm[17:15]);
      default:  return '0;
    endcase
  endfunction

  // Expected pad-facing vectors from the bench's own copy of the active config
  function automatic logic [127:0] model_of(kind_e k);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < NPADS; i++) begin
      case (k)
        K_OEB:    r[i] = mcfg[i][0] ? mcfg[i][1] : user_oeb[i];
        K_IOOUT:  r[i] = mcfg[i][0] ? mgmt_out[i] : user_out[i];
        K_DM:     r[3*i +: 3] = mcfg[i][5:3];
        K_INPDIS: r[i] = mcfg[i][2];
        default:  ;
      endcase
    end
    return r;
  endfunction

  function automatic logic [TOTAL-1:0] pack_cfg();
    logic [TOTAL-1:0] s;
    for (int i = 0; i < NPADS; i++) s[i*CFGW +: CFGW] = ncfg[i];
    return s;
  endfunction

  // Monitor: compare every expectation that falls due on this cycle
  always @(negedge clock) begin
    for (int j = sbq.size() - 1; j >= 0; j--) begin
      if (sbq[j].due <= cyc) begin
        checks++;
        if (sbq[j].due < cyc) begin
          failures++;
          $display("FAIL %s: check missed at cycle %0d, due %0d", sbq[j].name, cyc, sbq[j].due);
        end else begin
          act = actual_of(sbq[j].kind);
          if (act !== sbq[j].exp) begin
            failures++;
            $display("FAIL %s @cyc %0d: got %h required %h", sbq[j].name, cyc, act, sbq[j].exp);
          end
        end
        sbq.delete(j);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_at(input int due, input kind_e k, input logic [127:0] e, input string nm);
    exp_t x;
    x.due  = due;
    x.kind = k;
    x.exp  = e;
    x.name = nm;
    sbq.push_back(x);
  endtask

  task automatic push_outputs(input int due, input string tag);
    push_at(due, K_OEB,    model_of(K_OEB),    {tag, "_oeb"});
    push_at(due, K_IOOUT,  model_of(K_IOOUT),  {tag, "_io_out"});
    push_at(due, K_DM,     model_of(K_DM),     {tag, "_dm"});
    push_at(due, K_INPDIS, model_of(K_INPDIS), {tag, "_inp_dis"});
  endtask

  task automatic ncfg_def();
    for (int i = 0; i < NPADS; i++) ncfg[i] = DEF;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < NPADS; i++) mcfg[i] = DEF;
  endtask

  // Shift n bits MSB-first from s, with an idle gap now and then
  task automatic send_stream(input logic [TOTAL-1:0] s, input int n, input bit load_last,
                             output int lcyc);
    lcyc = -1;
    for (int k = 0; k < n; k++) begin
      if (k % 50 == 49) begin
        ser.ser_valid = 1'b0;
        tick();
      end
      ser.ser_valid = 1'b1;
      ser.ser_data  = s[TOTAL-1-k];
      if (load_last && k == n - 1) begin
        ser.ser_load = 1'b1;
        lcyc = cyc;
      end
      tick();
    end
    ser.ser_valid = 1'b0;
    ser.ser_load  = 1'b0;
  endtask

  task automatic do_load(output int lcyc);
    ser.ser_load = 1'b1;
    lcyc = cyc;
    tick();
    ser.ser_load = 1'b0;
  endtask

  // Busy pulse, old outputs during COMMIT, new (or unchanged) outputs after
  task automatic commit_expect(input int lcyc, input bit takes, input bit err, input string tag);
    push_at(lcyc + 1, K_BUSY, 128'(1), {tag, "_busy_hi"});
    push_at(lcyc + 2, K_BUSY, 128'(0), {tag, "_busy_lo"});
    push_outputs(lcyc + 1, {tag, "_old"});
    if (takes) mcfg = ncfg;
    push_outputs(lcyc + 2, {tag, "_new"});
    push_at(lcyc + 2, K_ERR, 128'(err), {tag, "_cfg_err"});
  endtask

  initial begin
    reset         = 1'b1;
    ser.ser_valid = 1'b0;
    ser.ser_data  = 1'b0;
    ser.ser_load  = 1'b0;
    mgmt_out      = 38'h2A_AAAA_AAAA;
    user_out      = 38'h15_5555_5555;
    user_oeb      = 38'h0F_0F0F_0F0F;
    io_in         = '1;
    junk          = '1;
    for (int i = 0; i < NPADS; i++) mcfg[i] = DEF;
    ncfg_def();
    tick();
    tick();
    tick();

    // Reset state, and the synchronizer holding mgmt_in low for two cycles
    reset = 1'b0;
    c0 = cyc;
    push_at(c0, K_OEB,    128'(38'h3F_FFFF_FFFF), "rst_oeb");
    push_at(c0, K_DM,     128'({38{3'b001}}),     "rst_dm");
    push_at(c0, K_INPDIS, 128'(0),                "rst_inp_dis");
    push_at(c0, K_IOOUT,  128'(38'h2A_AAAA_AAAA), "rst_io_out");
    push_at(c0, K_ERR,    128'(0),                "rst_cfg_err");
    push_at(c0, K_BUSY,   128'(0),                "rst_busy");
    push_at(c0, K_MGMTIN, 128'(0),                "rst_mgmt_in_c0");
    push_at(c0 + 1, K_MGMTIN, 128'(0),            "rst_mgmt_in_c1");
    push_at(c0 + 2, K_MGMTIN, 128'(38'h3F_FFFF_FFFF), "rst_mgmt_in_c2");
    push_at(c0 + 2, K_USERIN, 128'(0),            "rst_user_in_c2");
    repeat (3) tick();
    io_in = '0;
    repeat (3) tick();

    // Pad 5 handed to the user with drive mode 110
    ncfg_def();
    ncfg[5] = 6'b110_0_0_0;
    send_stream(pack_cfg(), TOTAL, 1'b0, lc);
    do_load(lc);
    commit_expect(lc, 1'b1, 1'b0, "pad5");
    push_at(lc + 2, K_DM5,  128'(3'b110), "pad5_dm_17_15");
    push_at(lc + 2, K_IO5,  128'(0),      "pad5_io_out_user");
    push_at(lc + 2, K_OEB5, 128'(0),      "pad5_oeb_user");
    push_at(lc + 1, K_OEB5, 128'(1),      "pad5_oeb_during_commit");
    repeat (3) tick();

    // One bit short: rejected and error latched; a full load then commits
    ncfg_def();
    ncfg[0]  = 6'b111_1_0_0;
    ncfg[37] = 6'b010_0_0_1;
    send_stream(pack_cfg(), TOTAL - 1, 1'b0, lc);
    do_load(lc);
    commit_expect(lc, 1'b0, 1'b1, "short");
    repeat (3) tick();
    send_stream(pack_cfg(), TOTAL, 1'b0, lc);
    do_load(lc);
    commit_expect(lc, 1'b1, 1'b1, "after_short");
    repeat (3) tick();

    // Last bit together with ser_load still counts
    do_reset();
    push_at(cyc, K_ERR, 128'(0), "reset_clears_err");
    ncfg_def();
    ncfg[1]  = 6'b001_0_1_0;
    ncfg[20] = 6'b100_1_1_1;
    send_stream(pack_cfg(), TOTAL, 1'b1, lc);
    commit_expect(lc, 1'b1, 1'b0, "load_with_last");
    repeat (3) tick();

    // Input synchronizer latency and routing by mgmt_en
    c0 = cyc;
    push_at(c0 + 1, K_MGMTIN, 128'(0), "sync_mgmt_in_c1");
    push_at(c0 + 1, K_USERIN, 128'(0), "sync_user_in_c1");
    io_in = 38'h0A;
    push_at(c0 + 2, K_MGMTIN, 128'(38'h08), "sync_mgmt_in_c2");
    push_at(c0 + 2, K_USERIN, 128'(38'h02), "sync_user_in_c2");
    repeat (3) tick();

    // inp_dis on pad 3 blocks both input paths
    ncfg[3] = 6'b001_1_1_1;
    send_stream(pack_cfg(), TOTAL, 1'b0, lc);
    do_load(lc);
    commit_expect(lc, 1'b1, 1'b0, "inp_dis3");
    push_at(lc + 1, K_MGMTIN, 128'(38'h08), "inp_dis3_mgmt_in_old");
    push_at(lc + 2, K_MGMTIN, 128'(0),      "inp_dis3_mgmt_in");
    push_at(lc + 2, K_USERIN, 128'(38'h02), "inp_dis3_user_in");
    repeat (3) tick();
    io_in = '0;
    repeat (3) tick();

    // Reset in the middle of a transfer aborts it; a later ser_load is ignored
    for (int i = 0; i < NPADS; i++) ncfg[i] = '0;
    send_stream(pack_cfg(), 100, 1'b0, lc);
    do_reset();
    do_load(lc);
    push_at(lc + 1, K_BUSY, 128'(0), "abort_busy");
    push_outputs(lc + 2, "abort");
    push_at(lc + 2, K_ERR, 128'(0), "abort_cfg_err");
    repeat (3) tick();

    // Over-long transfer (TOTAL+256 bits) must not be accepted
    send_stream(junk, TOTAL, 1'b0, lc);
    send_stream(junk, 28, 1'b0, lc);
    send_stream(pack_cfg(), TOTAL, 1'b0, lc);
    do_load(lc);
    commit_expect(lc, 1'b0, 1'b1, "overlong");
    repeat (4) tick();

    if (sbq.size() != 0) begin
      failures += sbq.size();
      $display("FAIL scoreboard_drain: pending=%0d required=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_pad_ctrl.md
GPIO_PAD_CTRL -- requirements
Module: gpio_pad_ctrl

Interface
REQ-001 Parameter NPADS, default 38: number of pads controlled, one control slice per pad.
REQ-002 Parameter CFGW, default 6: configuration bits per pad; bit0 mgmt_en, bit1 oeb_cfg, bit2 inp_dis, bits5:3 dm.
REQ-003 Parameter DEF_CFG, default 6'b001_0_1_1: per-pad reset configuration (mgmt_en=1, oeb_cfg=1, inp_dis=0, dm=3'b001).
REQ-004 The block SHALL have one clock, `clock`, and its reset, `reset`, SHALL be synchronous and active-high.
REQ-005 Port list (name, direction, width, meaning):
- clock, in, 1: sole clock.
- reset, in, 1: synchronous, active-high.
- ser_valid, in, 1: ser_data is valid this cycle.
- ser_data, in, 1: configuration bit; last pad's MSB first.
- ser_load, in, 1: commits the shifted chain.
- ser_busy, out, 1: high while in the COMMIT state.
- cfg_err, out, 1: sticky bit-count error.
- mgmt_out, in, NPADS: management output data.
- user_out, in, NPADS: user output data.
- user_oeb, in, NPADS: user output enable, active low.
- io_out, out, NPADS: output data to the pads.
- oeb, out, NPADS: pad output enable, active low.
- inp_dis, out, NPADS: pad input disable.
- dm, out, 3*NPADS: drive mode; pad i uses bits 3i+2:3i.
- io_in, in, NPADS: asynchronous pad inputs.
- mgmt_in, out, NPADS: synchronized input to management.
- user_in, out, NPADS: synchronized input to user.

Function
REQ-006 The block SHALL hold a shift chain of NPADS*CFGW bits and a separate active configuration register of the same width.
REQ-007 FSM states SHALL be IDLE, SHIFT and COMMIT.
REQ-008 IDLE -> SHIFT on ser_valid: the bit is shifted into chain LSB, and the bit counter is set to 1.
REQ-009 In SHIFT, each ser_valid SHALL shift one bit and increment the counter; the counter saturates at NPADS*CFGW+1.
REQ-010 ser_load in SHIFT -> COMMIT; ser_load in IDLE SHALL be ignored.
REQ-011 In COMMIT (exactly 1 cycle, ser_busy=1), the active register SHALL be updated only if the counter equals NPADS*CFGW.
- If the count differs, the active register is unchanged and cfg_err is set.
- The FSM then returns to IDLE and the counter clears.
REQ-012 ser_valid and ser_load in the same SHIFT cycle: the bit SHALL be shifted first and included in the count, then COMMIT is entered.
REQ-013 ser_valid during COMMIT SHALL be ignored and not counted.
REQ-014 New pad settings SHALL take effect on the cycle after COMMIT; the latency from the ser_load edge to a changed output is 2 cycles.
REQ-015 Output mux, per pad i:
- mgmt_en=1: io_out=mgmt_out[i], oeb=oeb_cfg.
- mgmt_en=0: io_out=user_out[i], oeb=user_oeb[i].
- Outputs SHALL be combinational from the active register and inputs.
REQ-016 inp_dis[i] and dm[i] SHALL come directly from the active register regardless of mgmt_en.
REQ-017 io_in SHALL pass through a 2-flop synchronizer. The synchronized value drives mgmt_in[i] when mgmt_en=1, else user_in[i]; the non-selected output is 0.
REQ-018 When inp_dis[i]=1, mgmt_in[i] and user_in[i] SHALL both be 0.
REQ-019 cfg_err SHALL clear only on reset.

Reset
REQ-020 On reset the following SHALL be set:
- FSM=IDLE, counter=0, chain=0.
- Active register = DEF_CFG replicated NPADS times.
- Synchronizer flops = 0, cfg_err=0, ser_busy=0.
REQ-021 After reset: oeb=all 1, io_out=mgmt_out, inp_dis=0, dm=3'b001 per pad, mgmt_in=0 for 2 cycles.
REQ-022 Reset during SHIFT or COMMIT SHALL abort the transfer with no commit.

Verification
REQ-023 Reset with NPADS=38: oeb=38'h3F_FFFF_FFFF, dm per pad=3'b001, cfg_err=0, ser_busy=0.
REQ-024 Shift 228 bits putting pad 5 at mgmt_en=0, oeb_cfg=0, dm=3'b110, then ser_load:
- ser_busy is high 1 cycle.
- 2 cycles after ser_load, dm[17:15]=3'b110 and io_out[5] follows user_out[5], oeb[5] follows user_oeb[5].
REQ-025 Shift 227 bits, then ser_load: outputs unchanged, cfg_err=1. Then a correct 228-bit load commits, and cfg_err stays 1.
REQ-026 228th bit issued together with ser_load: commit succeeds, cfg_err=0.
REQ-027 io_in[3] rising with mgmt_en=1: mgmt_in[3]=1 exactly 2 cycles later, user_in[3]=0. With inp_dis[3]=1: both 0.
REQ-028 Reset asserted mid-SHIFT after 100 bits, followed by ser_load: configuration stays at DEF_CFG and cfg_err=0.
